// File: rtl/cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : cmd_sequencer_if
// Purpose  : Host/core-facing bundle of the command sequencer: load handshake,
//            replay controls, the command bus toward the core and status.
// Revision : 1.0 - initial release
// ============================================================================
interface cmd_sequencer_if #(
  parameter int DEPTH = 16
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic          ena;
  logic          load_valid;
  logic          load_ready;
  logic [3:0]    load_opcode;
  logic [3:0]    load_addr;
  logic [3:0]    load_data;
  logic          load_we;
  logic          start;
  logic          stop;
  logic          clear;
  logic          loop_en;
  logic [3:0]    out_opcode;
  logic [3:0]    out_addr;
  logic [3:0]    out_data;
  logic          out_write_enable;
  logic          issue;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;

  // Host / testbench side
  modport master (
    output ena, load_valid, load_opcode, load_addr, load_data, load_we,
           start, stop, clear, loop_en,
    input  load_ready, out_opcode, out_addr, out_data, out_write_enable,
           issue, busy, done, count
  );

  // Sequencer side
  modport slave (
    input  ena, load_valid, load_opcode, load_addr, load_data, load_we,
           start, stop, clear, loop_en,
    output load_ready, out_opcode, out_addr, out_data, out_write_enable,
           issue, busy, done, count
  );

endinterface
`default_nettype wire

// File: rtl/cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cmd_sequencer
// Purpose  : Buffers a short host-loaded program of {opcode, addr, data, we}
//            commands and replays it to the seven-segment core, one command
//            every STEP_CYCLES clocks, optionally looping.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_sequencer #(
  parameter int DEPTH       = 16,
  parameter int STEP_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  cmd_sequencer_if.slave       bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] addr;
    logic [3:0] data;
    logic       we;
  } entry_t;

  entry_t          mem_q [DEPTH];

  state_t          state_q,      state_d;
  logic [CW-1:0]   count_q,      count_d;
  logic [PW-1:0]   rd_ptr_q,     rd_ptr_d;
  logic [TW-1:0]   timer_q,      timer_d;
  logic [3:0]      out_opcode_q, out_opcode_d;
  logic [3:0]      out_addr_q,   out_addr_d;
  logic [3:0]      out_data_q,   out_data_d;
  logic            out_we_q,     out_we_d;
  logic            issue_q,      issue_d;
  logic            done_q,       done_d;

  logic            load_ready;
  logic            accept;
  logic            wr_en;
  entry_t          wr_entry;
  entry_t          rd_entry;
  logic            timer_last;
  logic            ptr_last;

  // Loading is only possible while idle; a same-cycle clear refuses the
  // offer so the host never sees a handshake whose data is discarded.
  // The host is expected to hold load_valid low while ena is low.
  assign load_ready = (state_q == S_IDLE) && (count_q < CW'(DEPTH)) && !bus.clear;
  assign accept     = bus.load_valid && load_ready;

  assign wr_entry   = {bus.load_opcode, bus.load_addr, bus.load_data, bus.load_we};
  assign rd_entry   = mem_q[rd_ptr_q];
  assign timer_last = (timer_q == TW'(STEP_CYCLES - 1));
  assign ptr_last   = (CW'(rd_ptr_q) == (count_q - CW'(1)));

  // Next-state, storage-write and output computation; everything holds when ena is low
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    timer_d      = timer_q;
    out_opcode_d = out_opcode_q;
    out_addr_d   = out_addr_q;
    out_data_d   = out_data_q;
    out_we_d     = 1'b0;
    issue_d      = 1'b0;
    done_d       = 1'b0;
    wr_en        = 1'b0;

    if (bus.ena) begin
      case (state_q)
        S_IDLE: begin
          if (bus.clear) begin
            count_d = '0;
          end else begin
            if (accept) begin
              wr_en   = 1'b1;
              count_d = count_q + CW'(1);
            end
            // count_d already includes a command accepted this same cycle
            if (bus.start && (count_d != '0)) begin
              state_d  = S_RUN;
              rd_ptr_d = '0;
              timer_d  = '0;
            end
          end
        end

        S_RUN: begin
          if (bus.stop) begin
            state_d = S_IDLE;
          end else begin
            if (timer_q == '0) begin
              out_opcode_d = rd_entry.opcode;
              out_addr_d   = rd_entry.addr;
              out_data_d   = rd_entry.data;
              out_we_d     = rd_entry.we;
              issue_d      = 1'b1;
            end
            if (timer_last) begin
              timer_d = '0;
              if (!ptr_last) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
              end else if (bus.loop_en) begin
                rd_ptr_d = '0;
              end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end
            end else begin
              timer_d = timer_q + TW'(1);
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      timer_q      <= '0;
      out_opcode_q <= '0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      out_we_q     <= 1'b0;
      issue_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      timer_q      <= timer_d;
      out_opcode_q <= out_opcode_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      out_we_q     <= out_we_d;
      issue_q      <= issue_d;
      done_q       <= done_d;
    end
  end

  // Command storage; new entries land at the current fill level
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[count_q[PW-1:0]] <= wr_entry;
    end
  end

  assign bus.load_ready       = load_ready;
  assign bus.out_opcode       = out_opcode_q;
  assign bus.out_addr         = out_addr_q;
  assign bus.out_data         = out_data_q;
  assign bus.out_write_enable = out_we_q;
  assign bus.issue            = issue_q;
  assign bus.done             = done_q;
  assign bus.busy             = (state_q == S_RUN);
  assign bus.count            = count_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_sequencer
// Purpose  : Scoreboard bench for cmd_sequencer. The driver predicts every
//            issued command and done pulse as (enabled-edge stamp, payload)
//            from the program list; a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_sequencer;

  localparam int DEPTH = 16;
  localparam int STEP  = 4;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] addr;
    logic [3:0] data;
    logic       we;
  } cmd_t;

  typedef struct packed {
    int   stamp;
    cmd_t c;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_q;

  cmd_sequencer_if #(.DEPTH(DEPTH)) bus ();

  cmd_sequencer #(.DEPTH(DEPTH), .STEP_CYCLES(STEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Count of clock edges at which the design was enabled
  int en_cyc = 0;
  always @(posedge clk) begin
    if (bus.ena === 1'b1) en_cyc <= en_cyc + 1;
    rst_q <= rst;
  end

  ev_t  iq[$];
  int   dq[$];
  cmd_t prog[$];
  cmd_t last_exp;
  bit   mon_on = 1'b0;
  int   checks = 0;
  int   passes = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  // Monitor: compares every issue/done against the predicted queue and checks
  // that the command bus holds between issues.
  always @(negedge clk) begin
    if (mon_on) begin
      if (rst_q) last_exp = '0;
      if (bus.issue === 1'b1) begin
        ev_t e;
        if (iq.size() == 0) begin
          check("unexpected_issue", 1, 0);
        end else begin
          e = iq.pop_front();
          check("issue_time", en_cyc, e.stamp);
          check("issue_cmd",
                {bus.out_opcode, bus.out_addr, bus.out_data, bus.out_write_enable}, e.c);
          last_exp = e.c;
        end
      end else begin
        check("hold_outputs",
              {bus.out_opcode, bus.out_addr, bus.out_data, bus.out_write_enable},
              {last_exp.op, last_exp.addr, last_exp.data, 1'b0});
      end
      if (bus.done === 1'b1) begin
        int d;
        if (dq.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          d = dq.pop_front();
          check("done_time", en_cyc, d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input cmd_t c);
    bus.load_opcode = c.op;
    bus.load_addr   = c.addr;
    bus.load_data   = c.data;
    bus.load_we     = c.we;
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c = cmd_t'($urandom_range(0, 8191));
    return c;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.load_valid = 1'b1;
    set_load(cmd_t'(13'h1ABC));
    tick();
    rst = 1'b0;
    bus.load_valid = 1'b0;
    prog.delete();
    check("rst_count", bus.count, 0);
    check("rst_load_ready", bus.load_ready, 1);
    check("rst_outputs",
          {bus.out_opcode, bus.out_addr, bus.out_data, bus.out_write_enable,
           bus.issue, bus.busy, bus.done}, 0);
  endtask

  // Offer one command (optionally with clear) from IDLE and update the model
  task automatic offer(input cmd_t c, input bit clr);
    bit exp_ready;
    exp_ready = !clr && (prog.size() < DEPTH);
    set_load(c);
    bus.load_valid = 1'b1;
    bus.clear      = clr;
    #1;
    check("load_ready", bus.load_ready, exp_ready);
    tick();
    if (clr) prog.delete();
    else if (exp_ready) prog.push_back(c);
    bus.load_valid = 1'b0;
    bus.clear      = 1'b0;
    check("count", bus.count, prog.size());
  endtask

  // Start a replay and predict its issues/done. abort_at>0 asserts stop (or
  // rst) so that it is sampled at enabled edge k+abort_at.
  task automatic run(input bit loop, input int abort_at, input bit abort_rst,
                     input int frz_at, input int frz_len,
                     input bit with_load, input cmd_t lc);
    int k, len, endst, j, e;
    ev_t ev;
    bus.loop_en = loop;
    bus.start   = 1'b1;
    if (with_load) begin
      set_load(lc);
      bus.load_valid = 1'b1;
      if (prog.size() < DEPTH) prog.push_back(lc);
    end
    tick();
    bus.start      = 1'b0;
    bus.load_valid = 1'b0;
    k   = en_cyc;
    len = prog.size();
    if (len == 0) begin
      check("start_empty_busy", bus.busy, 0);
      repeat (2) tick();
      return;
    end
    endst = (abort_at > 0) ? k + abort_at : k + len * STEP;
    for (int m = 0; ; m++) begin
      e = k + 1 + m * STEP;
      if (e >= endst) break;
      if (!loop && m >= len) break;
      ev.stamp = e;
      ev.c     = prog[m % len];
      iq.push_back(ev);
    end
    if (abort_at == 0) dq.push_back(k + len * STEP);

    j = 0;
    forever begin
      if (frz_len > 0 && j == frz_at) begin
        bus.ena = 1'b0;
        repeat (frz_len) tick();
        bus.ena = 1'b1;
      end
      if (j == 1) check("busy_in_run", bus.busy, 1);
      if (abort_at > 0 && j == abort_at - 1) begin
        if (abort_rst) rst = 1'b1;
        else bus.stop = 1'b1;
        tick();
        rst      = 1'b0;
        bus.stop = 1'b0;
        break;
      end
      if (abort_at == 0 && j == len * STEP) break;
      tick();
      j++;
    end

    if (abort_rst) begin
      prog.delete();
      check("rst_run_outputs",
            {bus.out_opcode, bus.out_addr, bus.out_data, bus.out_write_enable,
             bus.issue, bus.done}, 0);
      check("rst_run_load_ready", bus.load_ready, 1);
    end
    check("busy_after", bus.busy, 0);
    check("count_kept", bus.count, prog.size());
    repeat (3) tick();
    check("issues_drained", iq.size(), 0);
    check("done_drained", dq.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    bus.ena         = 1'b1;
    bus.load_valid  = 1'b0;
    bus.load_opcode = '0;
    bus.load_addr   = '0;
    bus.load_data   = '0;
    bus.load_we     = 1'b0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.clear       = 1'b0;
    bus.loop_en     = 1'b0;
    last_exp        = '0;

    do_reset();
    mon_on = 1'b1;

    // Start with nothing stored is ignored
    run(0, 0, 0, 0, 0, 0, '0);

    // Three-command program: plain replay, loop+stop, and a freeze mid-run
    offer(cmd_t'({4'h1, 4'h2, 4'h5, 1'b1}), 0);
    offer(cmd_t'({4'h3, 4'h4, 4'h9, 1'b0}), 0);
    offer(cmd_t'({4'h7, 4'hF, 4'h0, 1'b1}), 0);
    run(0, 0, 0, 0, 0, 0, '0);
    run(1, 15, 0, 0, 0, 0, '0);
    run(0, 0, 0, 2, 3, 0, '0);

    // Clear with a simultaneous load stores nothing
    offer(rand_cmd(), 1);

    // Seventeen back-to-back offers: only sixteen fit; replay all of them
    for (int i = 0; i < DEPTH + 1; i++) offer(rand_cmd(), 0);
    check("full_count", bus.count, DEPTH);
    run(0, 0, 0, 0, 0, 0, '0);

    // Load and start together into an empty buffer
    offer(rand_cmd(), 1);
    run(0, 0, 0, 0, 0, 1, rand_cmd());

    // Reset in the middle of a replay
    offer(rand_cmd(), 0);
    offer(rand_cmd(), 0);
    run(0, 6, 1, 0, 0, 0, '0);

    // Randomised programs, loop modes, aborts and freezes
    for (int it = 0; it < 10; it++) begin
      int len, ab, fl, fa;
      bit lp, ar;
      offer(rand_cmd(), 1);
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) offer(rand_cmd(), 0);
      lp = 1'($urandom_range(0, 1));
      if (lp) ab = $urandom_range(1, 3 * len * STEP);
      else    ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, len * STEP - 1) : 0;
      ar = (ab > 0) && ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
      fa = $urandom_range(0, len * STEP);
      run(lp, ab, ar, fa, fl, 1'($urandom_range(0, 1)), rand_cmd());
    end

    check("final_issue_queue", iq.size(), 0);
    check("final_done_queue", dq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cmd_sequencer.md
Name: cmd_sequencer

Overview:
- Command sequencer that sits directly upstream of the seven-segment register/ALU core.
- Buffers a short program of opcode/address/data/write-enable commands loaded by a host.
- Replays the program to the core's in_opcode/in_addr/in_data/in_write_enable inputs, one command every STEP_CYCLES clocks, with optional looping.

Parameters:
- DEPTH, 16, command buffer entries; power of two, >=2.
- STEP_CYCLES, 4, clocks between successive issued commands; >=1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ena  in  1  design enable; low freezes sequencer
- load_valid  in  1  host offers a command
- load_ready  out  1  command accepted when load_valid && load_ready
- load_opcode  in  4  command opcode
- load_addr  in  4  command storage address
- load_data  in  4  command data
- load_we  in  1  command write-enable bit
- start  in  1  begin replay (level sampled)
- stop  in  1  abort replay
- clear  in  1  empty the buffer
- loop_en  in  1  restart at entry 0 after last entry
- out_opcode  out  4  to core in_opcode
- out_addr  out  4  to core in_addr
- out_data  out  4  to core in_data
- out_write_enable  out  1  to core in_write_enable; one-cycle pulse
- issue  out  1  one-cycle pulse on every issued command
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse on normal completion
- count  out  $clog2(DEPTH)+1  number of stored commands

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset (edge with rst=1), all registered values cleared:
  - state=IDLE; count, rd_ptr and timer = 0.
  - out_opcode/addr/data=0; out_write_enable, issue, busy and done = 0.
  - load_ready=1 after reset.
  - rst overrides every other input, including mid-RUN.
- ena=0: all state, pointers, timer and out_opcode/addr/data hold. out_write_enable, issue and done are cleared to 0 at that edge. Operation resumes unchanged when ena=1.
- Storage: DEPTH x 13-bit entries {opcode, addr, data, we}. A write to entry[count] happens on accept; count increments. No read-before-write hazard, because loading happens only in IDLE.
- load_ready (combinational) = state==IDLE && count<DEPTH && !clear.
- States:
  - IDLE:
    - clear=1 sets count=0. Clear wins over a load or start in the same cycle.
    - start=1 with count>0 (count includes a load accepted in the same cycle) goes to RUN, with rd_ptr=0 and timer=0.
    - start with count==0 is ignored.
  - RUN (busy=1):
    - On an edge with timer==0, register entry[rd_ptr] onto out_opcode/addr/data, pulse issue=1, and set out_write_enable=entry.we for that cycle.
    - out_opcode/addr/data hold until the next issue.
    - timer increments modulo STEP_CYCLES.
    - When timer==STEP_CYCLES-1 and rd_ptr!=count-1: rd_ptr increments at that edge.
    - When timer==STEP_CYCLES-1 and rd_ptr==count-1:
      - loop_en=1: rd_ptr=0 and continue.
      - loop_en=0: go to IDLE, done=1 for one cycle.
    - With STEP_CYCLES=1, one command issues every clock.
    - stop=1: go to IDLE at that edge. out_write_enable and issue are forced 0 at that edge; no done.
    - stop wins over a simultaneous issue or completion.
    - start, clear and load_valid are ignored in RUN.
- Latency: start sampled at edge k → entry 0 visible after edge k+1. Entry n is visible after edge k+1+n*STEP_CYCLES. With loop_en=0, done is visible after edge k+1+count*STEP_CYCLES-1... more precisely after edge k+count*STEP_CYCLES. busy deasserts at the same edge.
- count is unchanged by a replay; a program can be restarted with start.

Test Plan:
- Reset check: assert rst one cycle → all outputs 0, load_ready=1, count=0; a load offered during rst is not stored.
- Three-command replay, STEP_CYCLES=4, loop_en=0:
  - Load (1,2,5,we1), (3,4,9,we0), (7,F,0,we1), then pulse start at edge k.
  - Commands appear after edges k+1, k+5, k+9.
  - out_write_enable pulses only at k+1 and k+9; issue pulses at all three.
  - done and busy fall after edge k+12; count stays 3.
- Full buffer: offer 17 loads continuously → 16 accepted, load_ready=0 after the 16th, count=16, 17th not stored.
- Loop and abort: loop_en=1 with the three-command program → entry 0 reissues after edge k+13. stop at edge k+15 → IDLE, busy=0, no done, no further issue.
- Freeze: hold ena=0 for 3 cycles between issues → next issue delayed exactly 3 cycles. No write-enable or issue pulse while ena=0; outputs hold.
- Conflicts:
  - clear+load same cycle in IDLE → count=0, nothing stored.
  - load+start same cycle with empty buffer → RUN with count=1.
  - rst mid-RUN → IDLE, count=0, outputs 0 next cycle.
